// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter
//   Two-master to one-slave AXI4-Lite read-channel arbiter (AR + R only).
//   Master 0 is the instruction-fetch port and master 1 is the data (load) port.
//   Only one read is outstanding at a time. Each R beat is routed back to the
//   master that owns the current grant.
//
//   Optional build macro: ARB_ROUND_ROBIN_EN
//     When undefined, m1 has fixed priority over m0.
//     When defined, the two masters alternate under contention, tracked by a
//     1-bit last_grant register.
//
// Ports
//   clk, rst_n                : clock; asynchronous reset, active-high (1 = reset)
//   m0_*/m1_* AR              : araddr/arvalid in, arready out (combinational in IDLE)
//   m0_*/m1_* R               : rdata/rresp/rvalid out (combinational pass-through), rready in
//   s_araddr/s_arvalid        : registered slave AR request; s_arready in
//   s_rdata/s_rresp/s_rvalid  : slave R beat in; s_rready out (combinational)
//   busy                      : 1 whenever the FSM is not IDLE
//   grant_id                  : owner of the current or last transaction (0 = m0, 1 = m1)
module axi_lite_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,

    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_araddr;
    logic                r_grant;
    logic                w_any_req;
    logic                w_win_id;
    logic                w_accept;
    logic                w_rready;

    // A request is only considered while out of reset, so arready stays low during reset.
    assign w_any_req = (m0_arvalid | m1_arvalid) & ~rst_n;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // Remember the most recent winner so contention alternates between masters.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_last_grant <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_win_id;
        end
    end

    // Under contention pick the master that did not win last; a lone requester always wins.
    always_comb begin
        w_win_id = m1_arvalid;
        if (m0_arvalid && m1_arvalid) begin
            w_win_id = ~r_last_grant;
        end
    end
`else
    // Fixed priority: the data port (m1) wins whenever it requests.
    always_comb begin
        w_win_id = m1_arvalid;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winner's address and identity at the IDLE grant.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_araddr <= '0;
            r_grant  <= 1'b0;
        end else if (w_accept) begin
            r_araddr <= w_win_id ? m1_araddr : m0_araddr;
            r_grant  <= w_win_id;
        end
    end

    // Next-state and combinational handshake/routing outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rready     = 1'b0;
        m0_arready   = 1'b0;
        m1_arready   = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;
        m0_rdata     = '0;
        m1_rdata     = '0;
        m0_rresp     = 2'b00;
        m1_rresp     = 2'b00;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ADDR;
                    if (w_win_id) begin
                        m1_arready = 1'b1;
                    end else begin
                        m0_arready = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (s_arready) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_grant) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    w_rready  = m1_rready;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    w_rready  = m0_rready;
                end
                if (s_rvalid && w_rready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign s_rready  = w_rready;
    assign s_araddr  = r_araddr;
    assign s_arvalid = (r_state == ST_ADDR);
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed testbench for axi_lite_rd_arbiter.
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// well away from the rising (active) edge.
module tb_axi_lite_rd_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
    logic              m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]        m0_rresp, m1_rresp, s_rresp;
    logic              m0_rvalid, m0_rready, m1_rvalid, m1_rready;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic              busy, grant_id;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_total = 0;

    axi_lite_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count slave R handshakes on the active edge.
    always @(posedge clk) begin
        if (s_rvalid === 1'b1 && s_rready === 1'b1) hs_total = hs_total + 1;
    end

    task automatic test_reset();
        rst_n = 1'b1;
        m0_araddr = 32'h0000_0100; m0_arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++; if (m0_arready !== 1'b0) $display("FAIL reset_arready cyc%0d got %0b want 0", i, m0_arready); else n_pass++;
            n_checks++; if ({s_arvalid, busy, grant_id} !== 3'b000) $display("FAIL reset_state cyc%0d got arv/busy/gid %03b want 000", i, {s_arvalid, busy, grant_id}); else n_pass++;
        end
        n_checks++; if ({m0_rvalid, m1_rvalid, s_rready, m1_arready} !== 4'b0000) $display("FAIL reset_outs got %04b want 0000", {m0_rvalid, m1_rvalid, s_rready, m1_arready}); else n_pass++;
        n_checks++; if (s_araddr !== 32'h0) $display("FAIL reset_araddr got %08h want 00000000", s_araddr); else n_pass++;
        @(negedge clk);
        m0_arvalid = 1'b0;
        rst_n = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        m0_araddr = 32'h0000_0004; m0_arvalid = 1'b1; s_arready = 1'b1; m0_rready = 1'b1;
        #1;
        n_checks++; if ({m0_arready, m1_arready} !== 2'b10) $display("FAIL fetch_arready got m0/m1 %02b want 10", {m0_arready, m1_arready}); else n_pass++;
        @(negedge clk);
        m0_arvalid = 1'b0;
        #1;
        n_checks++; if (m0_arready !== 1'b0) $display("FAIL fetch_arready_pulse got %0b want 0", m0_arready); else n_pass++;
        n_checks++; if ({s_arvalid, busy, grant_id} !== 3'b110) $display("FAIL fetch_addr_state got %03b want 110", {s_arvalid, busy, grant_id}); else n_pass++;
        n_checks++; if (s_araddr !== 32'h0000_0004) $display("FAIL fetch_araddr got %08h want 00000004", s_araddr); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if ({s_arvalid, busy, m0_rvalid} !== 3'b010) $display("FAIL fetch_data_wait got %03b want 010", {s_arvalid, busy, m0_rvalid}); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'h0050_0093; s_rresp = 2'b00;
        #1;
        n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0050_0093) $display("FAIL fetch_rdata got v=%0b d=%08h want v=1 d=00500093", m0_rvalid, m0_rdata); else n_pass++;
        n_checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) $display("FAIL fetch_m1_quiet got v=%0b d=%08h want 0", m1_rvalid, m1_rdata); else n_pass++;
        n_checks++; if (s_rready !== 1'b1) $display("FAIL fetch_srready got %0b want 1", s_rready); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        n_checks++; if ({busy, m0_rvalid} !== 2'b00) $display("FAIL fetch_done got busy/rvalid %02b want 00", {busy, m0_rvalid}); else n_pass++;
    endtask

    task automatic test_contention();
        @(negedge clk);
        m0_araddr = 32'h0000_0008; m0_arvalid = 1'b1;
        m1_araddr = 32'h1000_0000; m1_arvalid = 1'b1;
        s_arready = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
        #1;
        n_checks++; if ({m0_arready, m1_arready} !== 2'b01) $display("FAIL cont_first_win got m0/m1 %02b want 01", {m0_arready, m1_arready}); else n_pass++;
        @(negedge clk);
        m1_arvalid = 1'b0;
        #1;
        n_checks++; if (grant_id !== 1'b1 || s_araddr !== 32'h1000_0000) $display("FAIL cont_m1_issue got gid=%0b addr=%08h want 1/10000000", grant_id, s_araddr); else n_pass++;
        n_checks++; if (m0_arready !== 1'b0) $display("FAIL cont_m0_blocked_addr got %0b want 0", m0_arready); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'hAAAA_0001;
        #1;
        n_checks++; if ({m1_rvalid, m0_rvalid, m0_arready} !== 3'b100) $display("FAIL cont_m1_data got m1v/m0v/m0ar %03b want 100", {m1_rvalid, m0_rvalid, m0_arready}); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        n_checks++; if ({busy, m0_arready, grant_id} !== 3'b011) $display("FAIL cont_idle_gap got busy/m0ar/gid %03b want 011", {busy, m0_arready, grant_id}); else n_pass++;
        @(negedge clk);
        m0_arvalid = 1'b0;
        #1;
        n_checks++; if (grant_id !== 1'b0 || s_araddr !== 32'h0000_0008) $display("FAIL cont_m0_issue got gid=%0b addr=%08h want 0/00000008", grant_id, s_araddr); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'hBBBB_0002;
        #1;
        n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hBBBB_0002 || m1_rvalid !== 1'b0) $display("FAIL cont_m0_data got v=%0b d=%08h m1v=%0b want 1/bbbb0002/0", m0_rvalid, m0_rdata, m1_rvalid); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        int hs_start;
        @(negedge clk);
        m1_araddr = 32'h2000_0040; m1_arvalid = 1'b1; s_arready = 1'b0; m1_rready = 1'b0;
        #1;
        n_checks++; if (m1_arready !== 1'b1) $display("FAIL bp_arready got %0b want 1", m1_arready); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m1_arvalid = 1'b0; m1_araddr = 32'hDEAD_BEEF;
            #1;
            n_checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h2000_0040) $display("FAIL bp_addr_stall cyc%0d got v=%0b a=%08h want 1/20000040", i, s_arvalid, s_araddr); else n_pass++;
        end
        @(negedge clk);
        s_arready = 1'b1;
        @(negedge clk);
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b00;
        hs_start = hs_total;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({s_rready, m1_rvalid, busy} !== 3'b011) $display("FAIL bp_r_stall cyc%0d got rdy/v/busy %03b want 011", i, {s_rready, m1_rvalid, busy}); else n_pass++;
            @(negedge clk);
        end
        m1_rready = 1'b1;
        #1;
        n_checks++; if (s_rready !== 1'b1 || m1_rdata !== 32'hCAFE_F00D) $display("FAIL bp_release got rdy=%0b d=%08h want 1/cafef00d", s_rready, m1_rdata); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        n_checks++; if (hs_total - hs_start !== 1 || busy !== 1'b0) $display("FAIL bp_one_handshake got hs=%0d busy=%0b want 1/0", hs_total - hs_start, busy); else n_pass++;
    endtask

    task automatic test_error_passthrough();
        @(negedge clk);
        m1_araddr = 32'h3000_0000; m1_arvalid = 1'b1; s_arready = 1'b1; m1_rready = 1'b1;
        @(negedge clk);
        m1_arvalid = 1'b0;
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'h0; s_rresp = 2'b10;
        #1;
        n_checks++; if (m1_rresp !== 2'b10 || m0_rresp !== 2'b00) $display("FAIL err_rresp got m1=%02b m0=%02b want 10/00", m1_rresp, m0_rresp); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b0; s_rresp = 2'b00;
        #1;
        n_checks++; if (busy !== 1'b0 || grant_id !== 1'b1) $display("FAIL err_idle got busy=%0b gid=%0b want 0/1", busy, grant_id); else n_pass++;
    endtask

    // Contention right after an m1-only grant: fixed priority keeps m1, round robin picks m0.
    task automatic test_priority_after_m1();
        logic exp_win;
`ifdef ARB_ROUND_ROBIN_EN
        exp_win = 1'b0;
`else
        exp_win = 1'b1;
`endif
        @(negedge clk);
        m0_araddr = 32'h0000_0010; m0_arvalid = 1'b1;
        m1_araddr = 32'h1000_0010; m1_arvalid = 1'b1;
        #1;
        n_checks++; if ({m1_arready, m0_arready} !== {exp_win, ~exp_win}) $display("FAIL prio_win got m1/m0 %0b%0b want %0b%0b", m1_arready, m0_arready, exp_win, ~exp_win); else n_pass++;
        @(negedge clk);
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        #1;
        n_checks++; if (grant_id !== exp_win) $display("FAIL prio_gid got %0b want %0b", grant_id, exp_win); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b1;
        @(negedge clk);
        s_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        @(negedge clk);
        m0_araddr = 32'h0000_0020; m0_arvalid = 1'b1; s_arready = 1'b1; m0_rready = 1'b1;
        @(negedge clk);
        m0_arvalid = 1'b0;
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rresp = 2'b11;
        #1;
        n_checks++; if (m0_rvalid !== 1'b1 || m0_rresp !== 2'b11) $display("FAIL rst_pre_data got v=%0b r=%02b want 1/11", m0_rvalid, m0_rresp); else n_pass++;
        rst_n = 1'b1; m0_arvalid = 1'b1; m0_araddr = 32'h0000_0044;
        #1;
        n_checks++; if ({m0_rvalid, s_rready, busy, s_arvalid, grant_id, m0_arready} !== 6'b0) $display("FAIL rst_async_ctrl got %06b want 000000", {m0_rvalid, s_rready, busy, s_arvalid, grant_id, m0_arready}); else n_pass++;
        n_checks++; if (m0_rdata !== 32'h0 || m0_rresp !== 2'b00 || s_araddr !== 32'h0) $display("FAIL rst_async_data got d=%08h r=%02b a=%08h want 0", m0_rdata, m0_rresp, s_araddr); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0; s_rvalid = 1'b0; s_rresp = 2'b00;
        #1;
        n_checks++; if (m0_arready !== 1'b1) $display("FAIL rst_after_accept got %0b want 1", m0_arready); else n_pass++;
        @(negedge clk);
        m0_arvalid = 1'b0;
        #1;
        n_checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h0000_0044) $display("FAIL rst_after_issue got v=%0b a=%08h want 1/00000044", s_arvalid, s_araddr); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'h0000_0055;
        #1;
        n_checks++; if (m0_rdata !== 32'h0000_0055 || m0_rvalid !== 1'b1) $display("FAIL rst_after_data got v=%0b d=%08h want 1/00000055", m0_rvalid, m0_rdata); else n_pass++;
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_after_idle got busy=%0b want 0", busy); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b1;
        m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b0;
        m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;

        test_reset();
        test_single_fetch();
        test_contention();
        test_backpressure();
        test_error_passthrough();
        test_priority_after_m1();
        test_reset_mid_data();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
